qpsk_hls_top_div_30s_15ns_30_seq: RTL
=====================================

# qpsk_hls_top_div_30s_15ns_30_seq

Sequential signed-by-unsigned divider that undoes the 15-bit × 15-bit → 30-bit scaling products in the QPSK datapath. Used on the receive/normalisation side to recover scaled symbol values from 30-bit accumulator words. It is a radix-2 restoring divider on magnitudes with sign correction. It uses a start/done handshake and the datapath's `ce` stall convention.

## Interface
- `din0_WIDTH`, default 30: dividend width, signed.
- `din1_WIDTH`, default 15: divisor width, unsigned.
- `LATENCY`, derived, din0_WIDTH+2 (32): fixed cycles from start acceptance to done.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ce` in 1: clock enable. When low, all state, counters and outputs hold.
- `start` in 1: request. Sampled only when `ce=1` and `ready=1`.
- `din0` in 30: signed dividend, captured on accept.
- `din1` in 15: unsigned divisor, captured on accept.
- `ready` out 1: high in IDLE and DONE.
- `done` out 1: one-`ce`-cycle pulse when results become valid.
- `quot` out 30: signed quotient, truncated toward zero.
- `rem` out 16: signed remainder. Carries the sign of the dividend, and |rem| < din1.
- `dbz` out 1: divide-by-zero flag, valid with `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**, on `start`:
  - Capture |din0| as 30-bit unsigned (−2^29 → 2^29 is legal), din1, and sign = din0[29].
  - Clear the 16-bit partial remainder; count = 0.
  - Go to CALC.
- **CALC**, one iteration per `ce` cycle:
  - Shift the {remainder, dividend} pair left by 1.
  - Trial-subtract the divisor. If non-negative, keep the result and shift in quotient bit 1; otherwise shift in 0.
  - After 30 iterations (count = 29), go to FIX.
- **FIX**:
  - If sign = 1: quot = −mag_q, rem = −mag_r.
  - If the captured divisor is 0: quot = 2^29−1 (sign=0) or −2^29 (sign=1), rem = 0, dbz = 1. The iteration result is discarded.
  - Register the outputs, then go to DONE.
- **DONE**:
  - `done` = 1 for one cycle.
  - `start` is accepted here: go to CALC with new operands. Otherwise go to IDLE.
- `start` in CALC or FIX is ignored; nothing is queued.
- `quot`, `rem` and `dbz` hold their last values until the next FIX.
- Inputs need only be stable in the accept cycle.
- Exact for all inputs: |quot| ≤ 2^29 and |rem| ≤ 2^15−2, so no overflow.

## Timing
- Reset (`reset_n=0` at a clock edge, regardless of `ce`):
  - state → IDLE; `ready=1`, `done=0`, `quot=0`, `rem=0`, `dbz=0`; count = 0.
  - Reset mid-operation aborts the operation with no `done`.
- Accept at edge T (`ce=1`, `ready=1`, `start=1`):
  - CALC occupies T+1..T+30 (with `ce` continuously high).
  - FIX at T+31.
  - `done=1` and new outputs visible at T+32, i.e. `LATENCY` = 32.
- `ready` drops the cycle after accept and returns with `done`.
- `ce` low for k cycles anywhere in an operation delays `done` by exactly k cycles. A `done` pulse held during a `ce`-low stretch stays high until the next `ce=1` edge.
- Back-to-back operations (start held high): one result every 32 cycles.

## Test plan
- din0=1000, din1=7, start pulse → `done` exactly 32 cycles after accept; quot=142, rem=6, dbz=0; `ready` low cycles 1–31.
- din0=−1000, din1=7 → quot=−142, rem=−6. Then din0=−536870912, din1=1 → quot=−536870912, rem=0. Then din0=536870911, din1=32767 → quot=16384, rem=16383.
- din1=0 with din0=5 → quot=536870911, rem=0, dbz=1. Next op with din1=3 → dbz=0.
- Extra start pulses with different operands during CALC → ignored; result matches the first operands; exactly one `done`.
- `ce` low for 5 cycles at CALC iteration 10 → `done` at cycle 37, result unchanged. `start` held high → second `done` exactly 32 cycles after the first.
- `reset_n` low at iteration 15 → next cycle: `ready=1`, outputs 0, no `done`. A fresh op after release completes normally.

Source files
------------

// File: rtl/qpsk_hls_top_div_30s_15ns_30_seq.sv
// Sequential signed-by-unsigned restoring divider: 30-bit signed dividend, 15-bit unsigned divisor.
// One quotient bit per ce cycle on magnitudes, then sign/divide-by-zero fix-up; start/done handshake.
module qpsk_hls_top_div_30s_15ns_30_seq #(
  parameter int din0_WIDTH = 30,
  parameter int din1_WIDTH = 15,
  parameter int LATENCY    = din0_WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    start,
  input  logic [din0_WIDTH-1:0]   din0,
  input  logic [din1_WIDTH-1:0]   din1,
  output logic                    ready,
  output logic                    done,
  output logic [din0_WIDTH-1:0]   quot,
  output logic [din1_WIDTH:0]     rem,
  output logic                    dbz
);

  localparam int DW    = din0_WIDTH;
  localparam int VW    = din1_WIDTH;
  localparam int RW    = din1_WIDTH + 1;
  localparam int CNT_W = $clog2(DW);
  // Last CALC iteration index: LATENCY minus the accept, FIX and DONE cycles.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(LATENCY - 3);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [DW-1:0]    dvd_q;
  logic [VW-1:0]    div_q;
  logic [RW-1:0]    rem_q;
  logic             sign_q;
  logic [DW-1:0]    quot_q;
  logic [RW-1:0]    rem_out_q;
  logic             dbz_q;

  logic [DW-1:0]    abs_din0;
  logic [RW-1:0]    rem_shift;
  logic [RW:0]      trial;
  logic [RW-1:0]    rem_d;
  logic [DW-1:0]    dvd_d;
  logic [DW-1:0]    quot_d;
  logic [RW-1:0]    rem_out_d;
  logic             dbz_d;

  // -2^29 maps to 2^29, which still fits the 30-bit unsigned magnitude.
  assign abs_din0 = din0[DW-1] ? (~din0 + 1'b1) : din0;

  // The partial remainder stays below the divisor, so its top bit is free for the shift.
  assign rem_shift = {rem_q[RW-2:0], dvd_q[DW-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, div_q};

  always_comb begin
    rem_d = rem_shift;
    dvd_d = {dvd_q[DW-2:0], 1'b0};
    if (!trial[RW]) begin
      rem_d = trial[RW-1:0];
      dvd_d = {dvd_q[DW-2:0], 1'b1};
    end
  end

  always_comb begin
    quot_d    = sign_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_out_d = sign_q ? (~rem_q + 1'b1) : rem_q;
    dbz_d     = 1'b0;
    if (div_q == '0) begin
      // Saturate toward the dividend's sign; the iteration result is meaningless.
      quot_d    = sign_q ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      rem_out_d = '0;
      dbz_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      dvd_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      sign_q    <= 1'b0;
      quot_q    <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else if (ce) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            dvd_q   <= abs_din0;
            div_q   <= din1;
            sign_q  <= din0[DW-1];
            rem_q   <= '0;
            count_q <= '0;
            state_q <= S_CALC;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_q   <= rem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          quot_q    <= quot_d;
          rem_out_q <= rem_out_d;
          dbz_q     <= dbz_d;
          state_q   <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done  = (state_q == S_DONE);
  assign quot  = quot_q;
  assign rem   = rem_out_q;
  assign dbz   = dbz_q;

endmodule
